amoeba_run_ctrl: RTL and testbench

AMOEBA_RUN_CTRL -- requirements
Module: amoeba_run_ctrl

---
 rtl/amoeba_pkg.sv | 28 ++
 rtl/amoeba_lfsr16.sv | 23 ++
 rtl/amoeba_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_amoeba_run_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/amoeba_pkg.sv
// Shared types and constants for the AMOEBA run controller.
package amoeba_pkg;

  // Run-controller FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESEED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Stochastic-gate thresholds are per-mille values carried in 10 bits.
  localparam int SG_W = 10;

  localparam logic [SG_W-1:0] SG1_DEF = 10'd10;
  localparam logic [SG_W-1:0] SG2_DEF = 10'd10;
  localparam logic [SG_W-1:0] SG3_DEF = 10'd90;

  // Exclusive upper bound of a per-mille threshold.
  localparam int PERMILLE_LIM = 1000;

  // Fold a raw 10-bit random value into 0..999: values 1000..1023 drop by
  // 512, which lands them in 488..511 and keeps the result in range.
  function automatic logic [SG_W-1:0] sg_fold(input logic [SG_W-1:0] v);
    return (v < SG_W'(PERMILLE_LIM)) ? v : v - SG_W'(512);
  endfunction

endpackage

// File: rtl/amoeba_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that free-runs out of reset.
module amoeba_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic fb;

  // Tap n of the polynomial is register bit n-1; shift toward the MSB.
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Advance every cycle; the seed must be non-zero or the sequence locks up.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], fb};
  end

endmodule

// File: rtl/amoeba_run_ctrl.sv
// Run controller for the AMOEBA SAT solver: watches unsat-count samples,
// detects solutions and stagnation, reseeds the stochastic gates from an
// LFSR, and times out after a bounded number of reseeds.
module amoeba_run_ctrl
  import amoeba_pkg::*;
#(
  parameter int          NUM_CLAUSES = 80,
  parameter int          CNT_W       = 7,
  parameter int          STALE_LIMIT = 100000,
  parameter int          MAX_EPOCHS  = 255,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             unsat_valid,
  input  logic [CNT_W-1:0] unsat_cnt,
  output logic             run_en,
  output logic [SG_W-1:0]  sg1,
  output logic [SG_W-1:0]  sg2,
  output logic [SG_W-1:0]  sg3,
  output logic             busy,
  output logic             solved,
  output logic             timeout,
  output logic             declining,
  output logic [CNT_W-1:0] best_unsat,
  output logic [7:0]       epoch
);

  localparam int                 STALE_W   = $clog2(STALE_LIMIT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(NUM_CLAUSES);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);
  localparam logic [7:0]         EPOCH_MAX = 8'(MAX_EPOCHS);

  state_t             state_q, state_d;
  logic [SG_W-1:0]    sg1_q, sg1_d, sg2_q, sg2_d, sg3_q, sg3_d;
  logic [STALE_W-1:0] stale_q, stale_d, stale_inc;
  logic [CNT_W-1:0]   prev_q, prev_d, best_q, best_d, cnt_c;
  logic [7:0]         epoch_q, epoch_d, epoch_inc;
  logic               solved_q, solved_d;
  logic               timeout_q, timeout_d;
  logic               declining_q, declining_d;
  logic [15:0]        lfsr;

  amoeba_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // Next-state and next-statistics logic for the whole controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sg1_d       = sg1_q;
    sg2_d       = sg2_q;
    sg3_d       = sg3_q;
    stale_d     = stale_q;
    prev_d      = prev_q;
    best_d      = best_q;
    epoch_d     = epoch_q;
    solved_d    = solved_q;
    timeout_d   = timeout_q;
    declining_d = declining_q;

    // Counts beyond the clause count are solver glitches; clamp them.
    cnt_c     = (unsat_cnt > CNT_MAX) ? CNT_MAX : unsat_cnt;
    stale_inc = (stale_q == STALE_MAX) ? stale_q : stale_q + 1'b1;
    epoch_inc = (epoch_q == 8'hFF) ? epoch_q : epoch_q + 8'd1;

    if (abort) begin
      // Abort wins over everything else and keeps the run's statistics.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d     = RUN;
            sg1_d       = SG1_DEF;
            sg2_d       = SG2_DEF;
            sg3_d       = SG3_DEF;
            stale_d     = '0;
            prev_d      = CNT_MAX;
            best_d      = CNT_MAX;
            epoch_d     = '0;
            solved_d    = 1'b0;
            timeout_d   = 1'b0;
            declining_d = 1'b0;
          end
        end

        RUN: begin
          if (unsat_valid) begin
            prev_d = cnt_c;
            best_d = (cnt_c < best_q) ? cnt_c : best_q;
            if (cnt_c < prev_q) begin
              stale_d     = '0;
              declining_d = 1'b0;
            end else begin
              stale_d = stale_inc;
              if (stale_inc == STALE_MAX) state_d = RESEED;
            end
            // A zero count is always an improvement, so it never collides
            // with the reseed branch above.
            if (cnt_c == '0) begin
              state_d  = DONE;
              solved_d = 1'b1;
            end
          end
        end

        RESEED: begin
          stale_d     = '0;
          declining_d = 1'b1;
          epoch_d     = epoch_inc;
          sg1_d       = sg_fold(lfsr[9:0]);
          sg2_d       = sg_fold(lfsr[15:6]);
          sg3_d       = sg_fold({lfsr[4:0], lfsr[15:11]});
          if (epoch_inc == EPOCH_MAX) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state register; reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sg1_q       <= SG1_DEF;
      sg2_q       <= SG2_DEF;
      sg3_q       <= SG3_DEF;
      stale_q     <= '0;
      prev_q      <= CNT_MAX;
      best_q      <= CNT_MAX;
      epoch_q     <= '0;
      solved_q    <= 1'b0;
      timeout_q   <= 1'b0;
      declining_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sg1_q       <= sg1_d;
      sg2_q       <= sg2_d;
      sg3_q       <= sg3_d;
      stale_q     <= stale_d;
      prev_q      <= prev_d;
      best_q      <= best_d;
      epoch_q     <= epoch_d;
      solved_q    <= solved_d;
      timeout_q   <= timeout_d;
      declining_q <= declining_d;
    end
  end

  assign run_en     = (state_q == RUN);
  assign busy       = (state_q == RUN) || (state_q == RESEED);
  assign sg1        = sg1_q;
  assign sg2        = sg2_q;
  assign sg3        = sg3_q;
  assign solved     = solved_q;
  assign timeout    = timeout_q;
  assign declining  = declining_q;
  assign best_unsat = best_q;
  assign epoch      = epoch_q;

endmodule

// File: tb/tb_amoeba_run_ctrl.sv
// Self-checking bench for amoeba_run_ctrl. Two instances share stimulus:
// dut_a reseeds after 4 stale samples, dut_b after 2 with 3 epochs max.
module tb_amoeba_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       unsat_valid = 1'b0;
  logic [6:0] unsat_cnt = '0;

  logic       a_run_en, a_busy, a_solved, a_timeout, a_declining;
  logic [9:0] a_sg1, a_sg2, a_sg3;
  logic [6:0] a_best;
  logic [7:0] a_epoch;
  logic       b_run_en, b_busy, b_solved, b_timeout, b_declining;
  logic [9:0] b_sg1, b_sg2, b_sg3;
  logic [6:0] b_best;
  logic [7:0] b_epoch;

  int n_checks = 0;
  int n_errors = 0;
  bit sel_b    = 1'b0;   // which instance the scoreboard compares against

  always #5 clk = ~clk;

  amoeba_run_ctrl #(.STALE_LIMIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .unsat_valid(unsat_valid), .unsat_cnt(unsat_cnt), .run_en(a_run_en),
    .sg1(a_sg1), .sg2(a_sg2), .sg3(a_sg3), .busy(a_busy), .solved(a_solved),
    .timeout(a_timeout), .declining(a_declining), .best_unsat(a_best),
    .epoch(a_epoch)
  );

  amoeba_run_ctrl #(.STALE_LIMIT(2), .MAX_EPOCHS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .unsat_valid(unsat_valid), .unsat_cnt(unsat_cnt), .run_en(b_run_en),
    .sg1(b_sg1), .sg2(b_sg2), .sg3(b_sg3), .busy(b_busy), .solved(b_solved),
    .timeout(b_timeout), .declining(b_declining), .best_unsat(b_best),
    .epoch(b_epoch)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, stepping every cycle.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [9:0] fold(input logic [9:0] v);
    if (v >= 10'd1000) return v - 10'd512;
    return v;
  endfunction

  typedef struct {
    string name;
    bit    start, abort, valid;
    int    cnt;
    bit    run_en, busy, solved, timeout, declining;
    int    best, epoch;
    bit    chk_sg;
  } vec_t;

  typedef struct {
    string       name;
    logic [19:0] obs;
    bit          chk_sg;
    logic [29:0] sg;
  } exp_t;

  vec_t vq[$];
  exp_t exp_q[$];

  function automatic vec_t v(string n, bit s, bit a, bit vl, int c,
                             bit re, bit bu, bit so, bit to, bit de,
                             int be, int ep, bit cs = 1'b0);
    vec_t r;
    r.name = n; r.start = s; r.abort = a; r.valid = vl; r.cnt = c;
    r.run_en = re; r.busy = bu; r.solved = so; r.timeout = to;
    r.declining = de; r.best = be; r.epoch = ep; r.chk_sg = cs;
    return r;
  endfunction

  function automatic logic [19:0] act_obs();
    if (sel_b) return {b_run_en, b_busy, b_solved, b_timeout, b_declining, b_best, b_epoch};
    return {a_run_en, a_busy, a_solved, a_timeout, a_declining, a_best, a_epoch};
  endfunction

  function automatic logic [29:0] act_sg();
    if (sel_b) return {b_sg1, b_sg2, b_sg3};
    return {a_sg1, a_sg2, a_sg3};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the clock edge.
  task automatic step(input vec_t t);
    exp_t e;
    start       = t.start;
    abort       = t.abort;
    unsat_valid = t.valid;
    unsat_cnt   = 7'(t.cnt);
    e.name   = t.name;
    e.obs    = {t.run_en, t.busy, t.solved, t.timeout, t.declining, 7'(t.best), 8'(t.epoch)};
    e.chk_sg = t.chk_sg;
    e.sg     = {fold(m_lfsr[9:0]), fold(m_lfsr[15:6]), fold({m_lfsr[4:0], m_lfsr[15:11]})};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(e.name, 64'(act_obs()), 64'(e.obs));
    if (e.chk_sg) check({e.name, "_sg"}, 64'(act_sg()), 64'(e.sg));
  endtask

  task automatic run_vq();
    foreach (vq[i]) step(vq[i]);
    vq.delete();
    start = 1'b0; abort = 1'b0; unsat_valid = 1'b0; unsat_cnt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; unsat_valid = 1'b0; unsat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state of both instances.
    do_reset();
    sel_b = 1'b0;
    check("reset_a", 64'(act_obs()), 64'({5'b00000, 7'd80, 8'd0}));
    check("reset_a_sg", 64'(act_sg()), 64'({10'd10, 10'd10, 10'd90}));
    sel_b = 1'b1;
    check("reset_b", 64'(act_obs()), 64'({5'b00000, 7'd80, 8'd0}));

    // Solve path, held DONE, restart from DONE, clamp, abort.
    sel_b = 1'b0;
    vq.push_back(v("sol_start", 1,0,0, 0,  1,1,0,0,0, 80,0));
    vq.push_back(v("sol_40",    0,0,1, 40, 1,1,0,0,0, 40,0));
    vq.push_back(v("sol_30",    0,0,1, 30, 1,1,0,0,0, 30,0));
    vq.push_back(v("sol_0",     0,0,1, 0,  0,0,1,0,0, 0, 0));
    vq.push_back(v("done_hold", 0,0,1, 50, 0,0,1,0,0, 0, 0));
    vq.push_back(v("restart",   1,0,0, 0,  1,1,0,0,0, 80,0));
    vq.push_back(v("clamp_100", 0,0,1, 100,1,1,0,0,0, 80,0));
    vq.push_back(v("abort_run", 0,1,0, 0,  0,0,0,0,0, 80,0));
    run_vq();

    // Stagnation to a single reseed cycle.
    do_reset();
    vq.push_back(v("rs_start", 1,0,0, 0,  1,1,0,0,0, 80,0));
    vq.push_back(v("rs_s1",    0,0,1, 20, 1,1,0,0,0, 20,0));
    vq.push_back(v("rs_s2",    0,0,1, 20, 1,1,0,0,0, 20,0));
    vq.push_back(v("rs_s3",    0,0,1, 20, 1,1,0,0,0, 20,0));
    vq.push_back(v("rs_s4",    0,0,1, 20, 1,1,0,0,0, 20,0));
    vq.push_back(v("rs_enter", 0,0,1, 20, 0,1,0,0,0, 20,0));
    vq.push_back(v("rs_exit",  0,0,1, 20, 1,1,0,0,1, 20,1, 1));
    vq.push_back(v("rs_run",   0,0,1, 25, 1,1,0,0,1, 20,1));
    run_vq();

    // Non-improving run that stays short of the limit.
    do_reset();
    vq.push_back(v("ni_start", 1,0,0, 0,  1,1,0,0,0, 80,0));
    vq.push_back(v("ni_30",    0,0,1, 30, 1,1,0,0,0, 30,0));
    vq.push_back(v("ni_25",    0,0,1, 25, 1,1,0,0,0, 25,0));
    vq.push_back(v("ni_25b",   0,0,1, 25, 1,1,0,0,0, 25,0));
    vq.push_back(v("ni_26",    0,0,1, 26, 1,1,0,0,0, 25,0));
    run_vq();
    check("ni_stale", 64'(dut_a.stale_q), 64'd2);
    vq.push_back(v("ni_idle",  0,0,0, 0,  1,1,0,0,0, 25,0));
    run_vq();

    // Abort beats a solution; abort beats start in IDLE.
    do_reset();
    vq.push_back(v("ab_start",  1,0,0, 0,  1,1,0,0,0, 80,0));
    vq.push_back(v("ab_10",     0,0,1, 10, 1,1,0,0,0, 10,0));
    vq.push_back(v("ab_vs_sol", 0,1,1, 0,  0,0,0,0,0, 10,0));
    vq.push_back(v("ab_vs_st",  1,1,0, 0,  0,0,0,0,0, 10,0));
    vq.push_back(v("ab_rerun",  1,0,0, 0,  1,1,0,0,0, 80,0));
    run_vq();

    // Three reseeds and timeout on dut_b.
    do_reset();
    sel_b = 1'b1;
    vq.push_back(v("to_start", 1,0,0, 0, 1,1,0,0,0, 80,0));
    vq.push_back(v("to_s1",    0,0,1, 5, 1,1,0,0,0, 5,0));
    vq.push_back(v("to_s2",    0,0,1, 5, 1,1,0,0,0, 5,0));
    vq.push_back(v("to_s3",    0,0,1, 5, 0,1,0,0,0, 5,0));
    vq.push_back(v("to_rs1",   0,0,1, 5, 1,1,0,0,1, 5,1, 1));
    vq.push_back(v("to_s4",    0,0,1, 5, 1,1,0,0,1, 5,1));
    vq.push_back(v("to_s5",    0,0,1, 5, 0,1,0,0,1, 5,1));
    vq.push_back(v("to_rs2",   0,0,1, 5, 1,1,0,0,1, 5,2, 1));
    vq.push_back(v("to_s6",    0,0,1, 5, 1,1,0,0,1, 5,2));
    vq.push_back(v("to_s7",    0,0,1, 5, 0,1,0,0,1, 5,2));
    vq.push_back(v("to_rs3",   0,0,1, 5, 0,0,0,1,1, 5,3, 1));
    vq.push_back(v("to_hold",  0,0,1, 0, 0,0,0,1,1, 5,3));
    vq.push_back(v("to_abort", 0,1,0, 0, 0,0,0,1,1, 5,3));
    run_vq();

    // Reset mid-run after a reseed, then start on the first edge after release.
    do_reset();
    vq.push_back(v("mr_start", 1,0,0, 0, 1,1,0,0,0, 80,0));
    vq.push_back(v("mr_s1",    0,0,1, 5, 1,1,0,0,0, 5,0));
    vq.push_back(v("mr_s2",    0,0,1, 5, 1,1,0,0,0, 5,0));
    vq.push_back(v("mr_s3",    0,0,1, 5, 0,1,0,0,0, 5,0));
    vq.push_back(v("mr_rs",    0,0,1, 5, 1,1,0,0,1, 5,1, 1));
    run_vq();
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rst_obs", 64'(act_obs()), 64'({5'b00000, 7'd80, 8'd0}));
    check("mr_rst_sg", 64'(act_sg()), 64'({10'd10, 10'd10, 10'd90}));
    check("mr_rst_lfsr", 64'(dut_b.lfsr), 64'h0000_0000_0000_ACE1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vq.push_back(v("mr_first_start", 1,0,0, 0, 1,1,0,0,0, 80,0));
    run_vq();
    check("mr_lfsr_step", 64'(dut_b.lfsr), 64'(m_lfsr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
